rename_register_file: RTL and testbench

Next-generation rename register file for the superscalar issue stage. It holds architectural data, a per-register valid bit and a per-register ROB tag.
- Serves IPC slots of two source lookups each, and IPC renames per cycle.
- Adds what the previous generation lacked: WB_PORTS commit ports, same-cycle commit bypass, intra-group dependency forwarding, flush recovery, and a reset-time init walk so the arrays can map to RAM.

---
 rtl/rename_register_file.sv | 191 +++++++++++++++++++
 tb/tb_rename_register_file.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_register_file.sv
`default_nettype none
// ============================================================================
// Module   : rename_register_file
// Purpose  : Rename register file (data/valid/tag) with commit bypass,
//            intra-group forwarding, flush recovery and reset-time init walk.
// Revision : 1.0
// ============================================================================
module rename_register_file #(
  parameter int IPC        = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int RF_WIDTH   = 5,
  parameter int WB_PORTS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           halt,
  input  logic                           flush,
  output logic                           RF_ready,
  input  logic [IPC-1:0]                 rs1_use,
  input  logic [IPC-1:0]                 rs2_use,
  input  logic [IPC*RF_WIDTH-1:0]        rs1,
  input  logic [IPC*RF_WIDTH-1:0]        rs2,
  input  logic [IPC-1:0]                 rd_valid,
  input  logic [IPC*RF_WIDTH-1:0]        rd,
  input  logic [IPC*TAG_WIDTH-1:0]       destinationTag,
  output logic [IPC*TAG_WIDTH-1:0]       rs1_tag,
  output logic [IPC*TAG_WIDTH-1:0]       rs2_tag,
  output logic [IPC-1:0]                 rs1_dataValid,
  output logic [IPC-1:0]                 rs2_dataValid,
  output logic [IPC*DATA_WIDTH-1:0]      rs1_data,
  output logic [IPC*DATA_WIDTH-1:0]      rs2_data,
  input  logic [WB_PORTS-1:0]            commit_valid,
  input  logic [WB_PORTS*RF_WIDTH-1:0]   commit_rd,
  input  logic [WB_PORTS*TAG_WIDTH-1:0]  commit_tag,
  input  logic [WB_PORTS*DATA_WIDTH-1:0] commit_data
);

  localparam int DEPTH = 2**RF_WIDTH;
  localparam logic [RF_WIDTH-1:0] C_LAST_IDX = RF_WIDTH'(DEPTH-1);
  localparam logic [RF_WIDTH-1:0] C_ONE      = RF_WIDTH'(1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [RF_WIDTH-1:0]   r_init_cnt, w_init_cnt_nxt;

  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [TAG_WIDTH-1:0]  r_tag  [DEPTH];
  logic [DEPTH-1:0]      r_valid;

  logic [RF_WIDTH-1:0]   w_src     [2][IPC];
  logic                  w_src_use [2][IPC];
  logic [RF_WIDTH-1:0]   w_rd      [IPC];
  logic [TAG_WIDTH-1:0]  w_dtag    [IPC];
  logic [RF_WIDTH-1:0]   w_crd     [WB_PORTS];
  logic [TAG_WIDTH-1:0]  w_ctag    [WB_PORTS];
  logic [DATA_WIDTH-1:0] w_cdata   [WB_PORTS];

  logic [TAG_WIDTH-1:0]  w_lk_tag   [2][IPC];
  logic                  w_lk_valid [2][IPC];
  logic [DATA_WIDTH-1:0] w_lk_data  [2][IPC];
  logic [TAG_WIDTH-1:0]  r_out_tag   [2][IPC];
  logic                  r_out_valid [2][IPC];
  logic [DATA_WIDTH-1:0] r_out_data  [2][IPC];

  generate
    for (genvar i = 0; i < IPC; i++) begin : g_slot
      assign w_src[0][i]     = rs1[i*RF_WIDTH +: RF_WIDTH];
      assign w_src[1][i]     = rs2[i*RF_WIDTH +: RF_WIDTH];
      assign w_src_use[0][i] = rs1_use[i];
      assign w_src_use[1][i] = rs2_use[i];
      assign w_rd[i]         = rd[i*RF_WIDTH +: RF_WIDTH];
      assign w_dtag[i]       = destinationTag[i*TAG_WIDTH +: TAG_WIDTH];
      assign rs1_tag[i*TAG_WIDTH +: TAG_WIDTH]    = r_out_tag[0][i];
      assign rs2_tag[i*TAG_WIDTH +: TAG_WIDTH]    = r_out_tag[1][i];
      assign rs1_dataValid[i]                     = r_out_valid[0][i];
      assign rs2_dataValid[i]                     = r_out_valid[1][i];
      assign rs1_data[i*DATA_WIDTH +: DATA_WIDTH] = r_out_data[0][i];
      assign rs2_data[i*DATA_WIDTH +: DATA_WIDTH] = r_out_data[1][i];
    end
    for (genvar p = 0; p < WB_PORTS; p++) begin : g_port
      assign w_crd[p]   = commit_rd[p*RF_WIDTH +: RF_WIDTH];
      assign w_ctag[p]  = commit_tag[p*TAG_WIDTH +: TAG_WIDTH];
      assign w_cdata[p] = commit_data[p*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign RF_ready = (r_state == ST_READY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    if (r_state == ST_INIT) begin
      w_init_cnt_nxt = r_init_cnt + C_ONE;
      if (r_init_cnt == C_LAST_IDX) w_state_nxt = ST_READY;
    end
  end

  // Later assignments override earlier ones: array < commit bypass < intra-group < x0 < use.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < IPC; i++) begin
        w_lk_tag[s][i]   = r_tag[w_src[s][i]];
        w_lk_valid[s][i] = r_valid[w_src[s][i]];
        w_lk_data[s][i]  = r_data[w_src[s][i]];
        for (int p = 0; p < WB_PORTS; p++) begin
          if (commit_valid[p] && (w_crd[p] == w_src[s][i]) && !r_valid[w_src[s][i]] &&
              (w_ctag[p] == r_tag[w_src[s][i]])) begin
            w_lk_valid[s][i] = 1'b1;
            w_lk_data[s][i]  = w_cdata[p];
          end
        end
        for (int j = 0; j < i; j++) begin
          if (rd_valid[j] && (w_rd[j] == w_src[s][i])) begin
            w_lk_tag[s][i]   = w_dtag[j];
            w_lk_valid[s][i] = 1'b0;
          end
        end
        if (w_src[s][i] == '0) begin
          w_lk_tag[s][i]   = '0;
          w_lk_valid[s][i] = 1'b1;
          w_lk_data[s][i]  = '0;
        end
        if (!w_src_use[s][i]) w_lk_valid[s][i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < IPC; i++) begin
          r_out_tag[s][i]   <= '0;
          r_out_valid[s][i] <= 1'b0;
          r_out_data[s][i]  <= '0;
        end
      end
    end else if (r_state == ST_READY) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < IPC; i++) begin
          if (flush) begin
            r_out_valid[s][i] <= 1'b0;
          end else if (!halt) begin
            r_out_tag[s][i]   <= w_lk_tag[s][i];
            r_out_valid[s][i] <= w_lk_valid[s][i];
            r_out_data[s][i]  <= w_lk_data[s][i];
          end
        end
      end
    end
  end

  // Arrays carry no reset so they can map to RAM; the init walk clears them instead.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_data[r_init_cnt]  <= '0;
      r_tag[r_init_cnt]   <= '0;
      r_valid[r_init_cnt] <= 1'b1;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (commit_valid[p] && (w_crd[p] != '0)) begin
          r_data[w_crd[p]] <= w_cdata[p];
          if (w_ctag[p] == r_tag[w_crd[p]]) r_valid[w_crd[p]] <= 1'b1;
        end
      end
      if (flush) begin
        r_valid <= '1;
      end else if (!halt) begin
        for (int i = 0; i < IPC; i++) begin
          if (rd_valid[i] && (w_rd[i] != '0)) begin
            r_valid[w_rd[i]] <= 1'b0;
            r_tag[w_rd[i]]   <= w_dtag[i];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rename_register_file.sv
`default_nettype none
// Testbench for rename_register_file: directed scenarios plus randomized traffic
// checked against a behavioural register-file model.
module tb_rename_register_file;
  localparam int IPC = 2, DW = 32, TW = 7, RW = 5, WB = 2, NREG = 32;

  logic clk = 1'b0, rst = 1'b1, halt, flush, RF_ready;
  logic [IPC-1:0] rs1_use, rs2_use, rd_valid, rs1_dataValid, rs2_dataValid;
  logic [IPC*RW-1:0] rs1, rs2, rd;
  logic [IPC*TW-1:0] destinationTag, rs1_tag, rs2_tag;
  logic [IPC*DW-1:0] rs1_data, rs2_data;
  logic [WB-1:0] commit_valid;
  logic [WB*RW-1:0] commit_rd;
  logic [WB*TW-1:0] commit_tag;
  logic [WB*DW-1:0] commit_data;

  int n_checks = 0, n_pass = 0;

  // Behavioural model state
  int init_left;
  logic [DW-1:0] m_data [NREG];
  logic          m_valid[NREG];
  logic [TW-1:0] m_tag  [NREG];
  logic [TW-1:0] e_tag [2][IPC];
  logic          e_dv  [2][IPC];
  logic [DW-1:0] e_data[2][IPC];
  logic          e_chk [2][IPC];
  logic          e_use [2][IPC];

  rename_register_file #(.IPC(IPC), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .RF_WIDTH(RW), .WB_PORTS(WB)) dut (
    .clk(clk), .rst(rst), .halt(halt), .flush(flush), .RF_ready(RF_ready),
    .rs1_use(rs1_use), .rs2_use(rs2_use), .rs1(rs1), .rs2(rs2),
    .rd_valid(rd_valid), .rd(rd), .destinationTag(destinationTag),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rs1_dataValid(rs1_dataValid), .rs2_dataValid(rs2_dataValid),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag), .commit_data(commit_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [RW-1:0] src_idx(int s, int i);
    return (s == 0) ? rs1[i*RW +: RW] : rs2[i*RW +: RW];
  endfunction
  function automatic logic src_use(int s, int i);
    return (s == 0) ? rs1_use[i] : rs2_use[i];
  endfunction
  function automatic logic out_dv(int s, int i);
    return (s == 0) ? rs1_dataValid[i] : rs2_dataValid[i];
  endfunction
  function automatic logic [TW-1:0] out_tag(int s, int i);
    return (s == 0) ? rs1_tag[i*TW +: TW] : rs2_tag[i*TW +: TW];
  endfunction
  function automatic logic [DW-1:0] out_data(int s, int i);
    return (s == 0) ? rs1_data[i*DW +: DW] : rs2_data[i*DW +: DW];
  endfunction

  function automatic void model_reset();
    init_left = NREG;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < IPC; i++) begin
        e_tag[s][i] = '0; e_dv[s][i] = 1'b0; e_data[s][i] = '0; e_chk[s][i] = 1'b1; e_use[s][i] = 1'b1;
      end
  endfunction

  // Advances the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    logic [DW-1:0] nd[NREG];
    logic          nv[NREG];
    logic [TW-1:0] nt[NREG];
    if (init_left > 0) begin
      init_left--;
      if (init_left == 0)
        for (int k = 0; k < NREG; k++) begin m_data[k] = '0; m_valid[k] = 1'b1; m_tag[k] = '0; end
      return;
    end
    if (flush) begin
      for (int s = 0; s < 2; s++) for (int i = 0; i < IPC; i++) begin e_dv[s][i] = 1'b0; e_chk[s][i] = 1'b0; end
    end else if (!halt) begin
      for (int s = 0; s < 2; s++) for (int i = 0; i < IPC; i++) begin
        logic [RW-1:0] idx;
        int found;
        idx = src_idx(s, i);
        found = -1;
        for (int j = 0; j < i; j++) if (rd_valid[j] && rd[j*RW +: RW] == idx) found = j;
        e_chk[s][i] = 1'b1;
        e_use[s][i] = src_use(s, i);
        if (idx == 0) begin
          e_tag[s][i] = '0; e_dv[s][i] = 1'b1; e_data[s][i] = '0;
        end else if (found >= 0) begin
          e_tag[s][i] = destinationTag[found*TW +: TW]; e_dv[s][i] = 1'b0; e_data[s][i] = m_data[idx];
        end else begin
          e_tag[s][i] = m_tag[idx]; e_dv[s][i] = m_valid[idx]; e_data[s][i] = m_data[idx];
          if (!m_valid[idx])
            for (int p = 0; p < WB; p++)
              if (commit_valid[p] && commit_rd[p*RW +: RW] == idx && commit_tag[p*TW +: TW] == m_tag[idx]) begin
                e_dv[s][i] = 1'b1; e_data[s][i] = commit_data[p*DW +: DW];
              end
        end
        if (!e_use[s][i]) e_dv[s][i] = 1'b0;
      end
    end
    for (int k = 0; k < NREG; k++) begin nd[k] = m_data[k]; nv[k] = m_valid[k]; nt[k] = m_tag[k]; end
    for (int p = 0; p < WB; p++) begin
      int r;
      r = int'(commit_rd[p*RW +: RW]);
      if (commit_valid[p] && r != 0) begin
        nd[r] = commit_data[p*DW +: DW];
        if (commit_tag[p*TW +: TW] == m_tag[r]) nv[r] = 1'b1;
      end
    end
    if (flush) begin
      for (int k = 0; k < NREG; k++) nv[k] = 1'b1;
    end else if (!halt) begin
      for (int i = 0; i < IPC; i++) begin
        int r;
        r = int'(rd[i*RW +: RW]);
        if (rd_valid[i] && r != 0) begin nv[r] = 1'b0; nt[r] = destinationTag[i*TW +: TW]; end
      end
    end
    for (int k = 0; k < NREG; k++) begin m_data[k] = nd[k]; m_valid[k] = nv[k]; m_tag[k] = nt[k]; end
  endfunction

  task automatic idle();
    halt = 0; flush = 0; rs1_use = '0; rs2_use = '0; rs1 = '0; rs2 = '0;
    rd_valid = '0; rd = '0; destinationTag = '0;
    commit_valid = '0; commit_rd = '0; commit_tag = '0; commit_data = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int cyc;
    idle();
    repeat (3) @(negedge clk);
    n_checks++; if (RF_ready !== 1'b0) $display("FAIL reset_ready: got %0d expected 0", RF_ready); else n_pass++;
    n_checks++; if ({rs1_dataValid, rs2_dataValid, rs1_tag, rs2_tag} !== '0) $display("FAIL reset_outs: got %0h expected 0", {rs1_dataValid, rs2_dataValid, rs1_tag, rs2_tag}); else n_pass++;
    n_checks++; if ({rs1_data, rs2_data} !== '0) $display("FAIL reset_data: got %0h expected 0", {rs1_data, rs2_data}); else n_pass++;
    rst = 0;
    model_reset();
    rd_valid[0] = 1'b1; rd[0 +: RW] = 5'd5; destinationTag[0 +: TW] = 7'h7F;  // must be ignored during init
    cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (RF_ready === 1'b1) begin cyc = k; break; end
    end
    n_checks++; if (cyc != 32) $display("FAIL init_cycles: got %0d expected 32", cyc); else n_pass++;
    idle();
    rs1[0 +: RW] = 5'd5; rs1_use[0] = 1'b1;
    tick();
    n_checks++; if (rs1_dataValid[0] !== 1'b1) $display("FAIL init_lookup_dv: got %0d expected 1", rs1_dataValid[0]); else n_pass++;
    n_checks++; if (rs1_data[0 +: DW] !== 32'h0) $display("FAIL init_lookup_data: got %0h expected 0", rs1_data[0 +: DW]); else n_pass++;
    n_checks++; if (rs1_tag[0 +: TW] !== 7'h0) $display("FAIL init_lookup_tag: got %0h expected 0", rs1_tag[0 +: TW]); else n_pass++;
  endtask

  task automatic test_rename_commit();
    idle(); rd_valid[0] = 1'b1; rd[0 +: RW] = 5'd3; destinationTag[0 +: TW] = 7'h11; tick();
    idle(); rs1[0 +: RW] = 5'd3; rs1_use[0] = 1'b1; tick();
    n_checks++; if (rs1_dataValid[0] !== 1'b0) $display("FAIL rename_dv: got %0d expected 0", rs1_dataValid[0]); else n_pass++;
    n_checks++; if (rs1_tag[0 +: TW] !== 7'h11) $display("FAIL rename_tag: got %0h expected 11", rs1_tag[0 +: TW]); else n_pass++;
    idle(); commit_valid[0] = 1'b1; commit_rd[0 +: RW] = 5'd3; commit_tag[0 +: TW] = 7'h11; commit_data[0 +: DW] = 32'hDEADBEEF; tick();
    idle(); rs1[0 +: RW] = 5'd3; rs1_use[0] = 1'b1; tick();
    n_checks++; if (rs1_dataValid[0] !== 1'b1) $display("FAIL commit_dv: got %0d expected 1", rs1_dataValid[0]); else n_pass++;
    n_checks++; if (rs1_data[0 +: DW] !== 32'hDEADBEEF) $display("FAIL commit_data: got %0h expected deadbeef", rs1_data[0 +: DW]); else n_pass++;
  endtask

  task automatic test_commit_bypass();
    idle(); rd_valid[0] = 1'b1; rd[0 +: RW] = 5'd3; destinationTag[0 +: TW] = 7'h11; tick();
    idle(); rs2[0 +: RW] = 5'd3; rs2_use[0] = 1'b1;
    commit_valid[1] = 1'b1; commit_rd[RW +: RW] = 5'd3; commit_tag[TW +: TW] = 7'h11; commit_data[DW +: DW] = 32'h55; tick();
    n_checks++; if (rs2_dataValid[0] !== 1'b1) $display("FAIL bypass_dv: got %0d expected 1", rs2_dataValid[0]); else n_pass++;
    n_checks++; if (rs2_data[0 +: DW] !== 32'h55) $display("FAIL bypass_data: got %0h expected 55", rs2_data[0 +: DW]); else n_pass++;
  endtask

  task automatic test_intra_group();
    idle(); rd_valid[0] = 1'b1; rd[0 +: RW] = 5'd7; destinationTag[0 +: TW] = 7'h20;
    rs1[0 +: RW] = 5'd7; rs1_use[0] = 1'b1; rs1[RW +: RW] = 5'd7; rs1_use[1] = 1'b1; tick();
    n_checks++; if (rs1_dataValid[1] !== 1'b0) $display("FAIL intra_dv: got %0d expected 0", rs1_dataValid[1]); else n_pass++;
    n_checks++; if (rs1_tag[TW +: TW] !== 7'h20) $display("FAIL intra_tag: got %0h expected 20", rs1_tag[TW +: TW]); else n_pass++;
    n_checks++; if (rs1_dataValid[0] !== 1'b1) $display("FAIL intra_slot0_dv: got %0d expected 1", rs1_dataValid[0]); else n_pass++;
    idle(); rd_valid = 2'b11; rd[0 +: RW] = 5'd9; rd[RW +: RW] = 5'd9;
    destinationTag[0 +: TW] = 7'h30; destinationTag[TW +: TW] = 7'h31; tick();
    idle(); rs1[0 +: RW] = 5'd9; rs1_use[0] = 1'b1; tick();
    n_checks++; if (rs1_tag[0 +: TW] !== 7'h31) $display("FAIL same_rd_tag: got %0h expected 31", rs1_tag[0 +: TW]); else n_pass++;
    n_checks++; if (rs1_dataValid[0] !== 1'b0) $display("FAIL same_rd_dv: got %0d expected 0", rs1_dataValid[0]); else n_pass++;
  endtask

  task automatic test_stale_commit_flush();
    idle(); rd_valid[0] = 1'b1; rd[0 +: RW] = 5'd4; destinationTag[0 +: TW] = 7'h40; tick();
    idle(); rd_valid[1] = 1'b1; rd[RW +: RW] = 5'd4; destinationTag[TW +: TW] = 7'h41; tick();
    idle(); commit_valid[0] = 1'b1; commit_rd[0 +: RW] = 5'd4; commit_tag[0 +: TW] = 7'h40; commit_data[0 +: DW] = 32'h9; tick();
    idle(); rs1[0 +: RW] = 5'd4; rs1_use[0] = 1'b1; tick();
    n_checks++; if (rs1_dataValid[0] !== 1'b0) $display("FAIL stale_dv: got %0d expected 0", rs1_dataValid[0]); else n_pass++;
    n_checks++; if (rs1_tag[0 +: TW] !== 7'h41) $display("FAIL stale_tag: got %0h expected 41", rs1_tag[0 +: TW]); else n_pass++;
    idle(); flush = 1'b1; rs1_use = 2'b11; rs2_use = 2'b11; rs1[0 +: RW] = 5'd4; tick();
    n_checks++; if ({rs1_dataValid, rs2_dataValid} !== 4'b0) $display("FAIL flush_dv: got %0h expected 0", {rs1_dataValid, rs2_dataValid}); else n_pass++;
    idle(); rs1[0 +: RW] = 5'd4; rs1_use[0] = 1'b1; tick();
    n_checks++; if (rs1_dataValid[0] !== 1'b1) $display("FAIL post_flush_dv: got %0d expected 1", rs1_dataValid[0]); else n_pass++;
    n_checks++; if (rs1_data[0 +: DW] !== 32'h9) $display("FAIL post_flush_data: got %0h expected 9", rs1_data[0 +: DW]); else n_pass++;
  endtask

  task automatic test_halt();
    idle(); halt = 1'b1; rs1[0 +: RW] = 5'd3; rs1_use[0] = 1'b1;
    rd_valid[0] = 1'b1; rd[0 +: RW] = 5'd5; destinationTag[0 +: TW] = 7'h50;
    commit_valid[0] = 1'b1; commit_rd[0 +: RW] = 5'd6; commit_tag[0 +: TW] = 7'h0; commit_data[0 +: DW] = 32'h66; tick();
    n_checks++; if (rs1_data[0 +: DW] !== 32'h9) $display("FAIL halt_hold_data: got %0h expected 9", rs1_data[0 +: DW]); else n_pass++;
    idle(); rs1[0 +: RW] = 5'd5; rs1_use[0] = 1'b1; rs2[0 +: RW] = 5'd6; rs2_use[0] = 1'b1; tick();
    n_checks++; if (rs1_dataValid[0] !== 1'b1) $display("FAIL halt_no_rename: got %0d expected 1", rs1_dataValid[0]); else n_pass++;
    n_checks++; if (rs2_data[0 +: DW] !== 32'h66) $display("FAIL halt_commit_data: got %0h expected 66", rs2_data[0 +: DW]); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      halt  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      rs1_use = IPC'($urandom); rs2_use = IPC'($urandom); rd_valid = IPC'($urandom);
      for (int i = 0; i < IPC; i++) begin
        rs1[i*RW +: RW] = RW'($urandom_range(0, 7));
        rs2[i*RW +: RW] = RW'($urandom_range(0, 7));
        rd[i*RW +: RW]  = RW'($urandom_range(0, 7));
        destinationTag[i*TW +: TW] = TW'($urandom);
      end
      for (int p = 0; p < WB; p++) begin
        logic [RW-1:0] r;
        r = RW'($urandom_range(0, 7));
        commit_valid[p] = $urandom_range(0, 1) == 1;
        commit_rd[p*RW +: RW] = r;
        commit_tag[p*TW +: TW] = ($urandom_range(0, 3) != 0) ? m_tag[r] : TW'($urandom);
        commit_data[p*DW +: DW] = $urandom;
      end
      tick();
      n_checks++; if (RF_ready !== 1'b1) $display("FAIL rnd_ready c%0d: got %0d expected 1", c, RF_ready); else n_pass++;
      for (int s = 0; s < 2; s++) for (int i = 0; i < IPC; i++) begin
        n_checks++;
        if (out_dv(s, i) !== e_dv[s][i]) $display("FAIL rnd_dv c%0d s%0d i%0d: got %0d expected %0d", c, s, i, out_dv(s, i), e_dv[s][i]);
        else n_pass++;
        if (e_chk[s][i] && e_use[s][i]) begin
          n_checks++;
          if (out_tag(s, i) !== e_tag[s][i]) $display("FAIL rnd_tag c%0d s%0d i%0d: got %0h expected %0h", c, s, i, out_tag(s, i), e_tag[s][i]);
          else n_pass++;
          if (e_dv[s][i]) begin
            n_checks++;
            if (out_data(s, i) !== e_data[s][i]) $display("FAIL rnd_data c%0d s%0d i%0d: got %0h expected %0h", c, s, i, out_data(s, i), e_data[s][i]);
            else n_pass++;
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    idle(); rd_valid[0] = 1'b1; rd[0 +: RW] = 5'd10; destinationTag[0 +: TW] = 7'h12;
    rs1[0 +: RW] = 5'd10; rs1_use[0] = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (RF_ready !== 1'b0) $display("FAIL mid_rst_ready: got %0d expected 0", RF_ready); else n_pass++;
    n_checks++; if ({rs1_dataValid, rs2_dataValid, rs1_tag, rs2_tag, rs1_data, rs2_data} !== '0) $display("FAIL mid_rst_outs: got nonzero expected 0"); else n_pass++;
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    idle();
    cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (RF_ready === 1'b1) begin cyc = k; break; end
    end
    n_checks++; if (cyc != 32) $display("FAIL reinit_cycles: got %0d expected 32", cyc); else n_pass++;
    for (int r = 0; r < NREG; r += 4) begin
      idle(); rs1_use = 2'b11; rs2_use = 2'b11;
      rs1[0 +: RW] = RW'(r); rs1[RW +: RW] = RW'(r + 1); rs2[0 +: RW] = RW'(r + 2); rs2[RW +: RW] = RW'(r + 3);
      tick();
      n_checks++;
      if ({rs1_dataValid, rs2_dataValid} !== 4'hF || {rs1_data, rs2_data} !== '0 || {rs1_tag, rs2_tag} !== '0)
        $display("FAIL reinit_regs r%0d: got dv=%0h data=%0h tag=%0h expected dv=f data=0 tag=0", r, {rs1_dataValid, rs2_dataValid}, {rs1_data, rs2_data}, {rs1_tag, rs2_tag});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_rename_commit();
    test_commit_bypass();
    test_intra_group();
    test_stale_commit_flush();
    test_halt();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
